// File: rtl/mult_pkg.sv
// Shared definitions for the signed shift-add multiplier sequencer.
package mult_pkg;

    // Default operand width in bits.
    localparam int unsigned DefaultWidth = 8;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StCalc = 3'd2,
        StSign = 3'd3,
        StDone = 3'd4
    } mult_state_e;

endpackage

// File: rtl/operand_magnitude.sv
// Splits a signed two's-complement operand into an unsigned magnitude and a sign bit.
// The most negative value maps to the unsigned magnitude 2^(WIDTH-1), which still fits in WIDTH
// bits when read as unsigned.
module operand_magnitude
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] magnitude,
    output logic             sign
);

    // Conditional two's-complement negation driven by the operand MSB.
    always_comb begin
        sign      = value[WIDTH-1];
        magnitude = sign ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/signed_mult_sequencer.sv
// Sequential signed multiplier: sign-magnitude split, WIDTH shift-add steps, final negation.
// Optional build macro SIGNED_MULT_EARLY_TERM_EN: leave the shift-add phase as soon as the
// remaining multiplier bits are all zero, folding the outstanding alignment shift into that step.
module signed_mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 ready
);

    localparam int unsigned AccW = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    mult_state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;          // sampled multiplicand
    logic [WIDTH-1:0] b_q, b_d;          // sampled multiplier
    logic [WIDTH-1:0] mcand_q, mcand_d;  // multiplicand magnitude
    logic [WIDTH-1:0] mp_q, mp_d;        // remaining multiplier magnitude bits
    logic [AccW-1:0]  acc_q, acc_d;
    logic [AccW-1:0]  product_q, product_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             sign_a, sign_b;

    logic [AccW:0]    step_sum;
    logic [WIDTH-1:0] mp_shifted;
    logic [CntW-1:0]  shamt;
    logic             calc_last;

    operand_magnitude #(
        .WIDTH (WIDTH)
    ) u_mag_a (
        .value     (a_q),
        .magnitude (mag_a),
        .sign      (sign_a)
    );

    operand_magnitude #(
        .WIDTH (WIDTH)
    ) u_mag_b (
        .value     (b_q),
        .magnitude (mag_b),
        .sign      (sign_b)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus busy/ready, both pure functions of the current state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StCalc;
            StCalc: begin
                if (calc_last) begin
                    state_d = StSign;
                end
            end
            StSign: state_d = StDone;
            StDone: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                busy    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // One shift-add step; the carry out of the upper half is kept in step_sum's top bit.
    always_comb begin
        mp_shifted = mp_q >> 1;
        step_sum   = {1'b0, acc_q} + (mp_q[0] ? {1'b0, mcand_q, {WIDTH{1'b0}}} : '0);
`ifdef SIGNED_MULT_EARLY_TERM_EN
        // With no multiplier bits left, the remaining steps are pure shifts: do them all now.
        calc_last  = (cnt_q == CntW'(1)) || (mp_shifted == '0);
        shamt      = calc_last ? cnt_q : CntW'(1);
`else
        calc_last  = (cnt_q == CntW'(1));
        shamt      = CntW'(1);
`endif
    end

    // Datapath next-state values, selected by the current sequencer state.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        mcand_d   = mcand_q;
        mp_d      = mp_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d = multiplicand;
                    b_d = multiplier;
                end
            end
            StLoad: begin
                mcand_d = mag_a;
                mp_d    = mag_b;
                sign_d  = sign_a ^ sign_b;
                zero_d  = (mag_a == '0) || (mag_b == '0);
                acc_d   = '0;
                cnt_d   = CntW'(WIDTH);
            end
            StCalc: begin
                acc_d = AccW'(step_sum >> shamt);
                mp_d  = mp_shifted;
                cnt_d = calc_last ? '0 : cnt_q - CntW'(1);
            end
            StSign: begin
                // A zero operand always yields +0, whatever the operand signs.
                if (zero_q) begin
                    product_d = '0;
                end else if (sign_q) begin
                    product_d = AccW'(0) - acc_q;
                end else begin
                    product_d = acc_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything so an abandoned operation leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            mp_q      <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            mcand_q   <= mcand_d;
            mp_q      <= mp_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_signed_mult_sequencer.sv
// Self-checking bench for signed_mult_sequencer (WIDTH=8): a cycle-level reference model plus
// directed operations with hand-computed products and latencies.
module tb_signed_mult_sequencer;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic [PW-1:0] product;
    logic          busy;
    logic          ready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    signed_mult_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .product      (product),
        .busy         (busy),
        .ready        (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Start-to-ready latency from the operand values alone.
    function automatic int model_lat(input logic [W-1:0] mb);
`ifdef SIGNED_MULT_EARLY_TERM_EN
        int m;
        int hb;
        m  = mb[W-1] ? -int'($signed(mb)) : int'(mb);
        hb = 0;
        for (int i = 0; i < W + 1; i++) begin
            if (((m >> i) & 1) != 0) hb = i;
        end
        return hb + 4;
`else
        return W + 3;
`endif
    endfunction

    // Reference model: which cycle an accepted op finishes and what product it leaves behind.
    int            cyc    = 0;
    bit            active = 1'b0;
    int            st_cyc = 0;
    int            lat    = 0;
    logic [PW-1:0] cur_p  = '0;
    logic [PW-1:0] prev_p = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cur_p  <= '0;
            prev_p <= '0;
        end else if (start && !(active && cyc <= st_cyc + lat)) begin
            active <= 1'b1;
            st_cyc <= cyc;
            lat    <= model_lat(b);
            prev_p <= active ? cur_p : prev_p;
            cur_p  <= PW'(int'($signed(a)) * int'($signed(b)));
        end
    end

    logic          exp_busy;
    logic          exp_ready;
    logic [PW-1:0] exp_p;

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        exp_busy  = active && (cyc >= st_cyc + 1) && (cyc <= st_cyc + lat);
        exp_ready = active && (cyc == st_cyc + lat);
        exp_p     = (active && cyc >= st_cyc + lat) ? cur_p : prev_p;
        check("busy", 32'(busy), 32'(exp_busy));
        check("ready", 32'(ready), 32'(exp_ready));
        check("product", 32'(product), 32'(exp_p));
    end

    // One operation with literal expectations; optional start glitch during the calculation.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [PW-1:0] exp_prod, input int lat_full,
                          input int lat_early, input bit glitch);
        int k;
        int exp_lat;
`ifdef SIGNED_MULT_EARLY_TERM_EN
        exp_lat = lat_early;
`else
        exp_lat = lat_full;
`endif
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        while (!ready && k < 40) begin
            @(negedge clk);
            k++;
            if (glitch && k == 3) begin
                a     = ~ta;
                b     = 8'h09;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", 32'(k), 32'(exp_lat));
        check("result", 32'(product), 32'(exp_prod));
        @(negedge clk);
        check("ready_once", 32'(ready), 32'd0);
        check("result_hold", 32'(product), 32'(exp_prod));
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(8'd5,   8'd3,   16'h000F, 11, 5,  1'b0);
        run_op(8'hF9,  8'd6,   16'hFFD6, 11, 6,  1'b0);
        run_op(8'h80,  8'h80,  16'h4000, 11, 11, 1'b0);
        run_op(8'h00,  8'hFB,  16'h0000, 11, 6,  1'b0);
        run_op(8'd127, 8'hFF,  16'hFF81, 11, 4,  1'b0);
        run_op(8'hFF,  8'hFF,  16'h0001, 11, 4,  1'b0);
        run_op(8'd127, 8'd127, 16'h3F01, 11, 10, 1'b0);
        run_op(8'd5,   8'd3,   16'h000F, 11, 5,  1'b1);
        run_op(8'd127, 8'hFF,  16'hFF81, 11, 4,  1'b0);

        // Abandon an operation mid-calculation.
        @(negedge clk);
        a     = 8'd7;
        b     = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (14) @(negedge clk);

        run_op(8'd3, 8'd2, 16'h0006, 11, 5, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
